fns_serial_decoder: RTL
=======================

Name: fns_serial_decoder

Overview:
- Receive-side decoder for the Fibonacci-numeral-system (FNS) TSV link.
- Takes a received TSV word and the matching per-TSV enable flags, where faulty and redundant TSVs are disabled. Reconstructs the binary value by walking the TSVs serially and giving successive Fibonacci weights 1, 2, 3, 5, 8, … to the enabled TSVs only.
- It is the counterpart of the transmit-side weight-assignment adder chain. It sits behind the TSV array, before the downstream binary datapath.

Parameters:
- N_TSV, 9, number of physical TSVs (x+y), including redundant ones.
- SUM_W, 8, width of the decoded value and the weight registers. Must hold the sum of the first N_TSV weights; that sum is 142 for N_TSV = 9.
- IDX_W, 4, width of the TSV index counter; must satisfy 2^IDX_W > N_TSV.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, rx_word and en_flag are valid.
- in_ready, output, 1, decoder can accept a word.
- rx_word, input, N_TSV, received TSV bits; bit 0 is the first TSV.
- en_flag, input, N_TSV, 1 = TSV carries a weight, 0 = faulty or redundant (skipped).
- out_valid, output, 1, dec_value is valid.
- out_ready, input, 1, downstream accepts dec_value.
- dec_value, output, SUM_W, decoded binary value.
- err, output, 1, FNS pattern violation flag; see Optional Feature.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high, on rst.
- Values after reset:
  - State is IDLE.
  - in_ready=1, out_valid=0, dec_value=0, err=0.
  - Internal accumulator and index are 0; prev=1, cur=1.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture rx_word and en_flag into shadow registers.
  - Clear the accumulator and set idx=0, prev=1, cur=1.
  - Go to RUN.
- RUN:
  - in_ready=0. One TSV is processed per cycle, at position idx.
  - If en_sh[idx]=1:
    - Add cur to acc when rx_sh[idx]=1.
    - Then update the weights: prev<=cur, cur<=prev+cur.
  - If en_sh[idx]=0: acc, prev and cur hold.
  - idx increments each cycle.
  - On the cycle idx=N_TSV-1 the final step completes, dec_value<=acc result, and the state goes to DONE.
- DONE:
  - out_valid=1; dec_value and err are held stable.
  - On out_valid&out_ready: out_valid<=0 and go to IDLE. in_ready becomes 1 on the following cycle; there is no same-cycle accept in DONE.
- Latency: accept at edge 0; out_valid is high after edge N_TSV, i.e. N_TSV cycles later (9 by default).
- Throughput: at most one word per N_TSV+2 cycles when out_ready is held high.
- Arithmetic:
  - All sums are unsigned, SUM_W-bit, with no saturation.
  - cur's update past the last used weight may wrap; it is never consumed.
- Boundary conditions:
  - en_flag=0: dec_value=0, no weight update.
  - All TSVs enabled: weights 1, 2, 3, 5, 8, 13, 21, 34, 55.
  - in_valid asserted during RUN or DONE: ignored; the upstream holds it because in_ready=0.
  - out_ready asserted outside DONE: ignored.
  - rst at any point, including mid-RUN: abort at once to the reset values; no partial output is produced.
  - rx_word and en_flag changing after accept: no effect, because the shadow registers are used.

Optional Feature:
- Macro: FNS_DECODER_CHECK_EN.
- Defined:
  - During RUN, track the rx bit of the last enabled TSV.
  - If two consecutive enabled TSVs are both 1, latch err=1. This is the FNS adjacent-ones violation; disabled TSVs between them are transparent.
  - err is cleared on accept in IDLE and is valid with out_valid.
  - dec_value is still computed normally.
- Not defined: err is tied to 0 and no tracking logic is built.

Test Plan:
- en_flag=9'h1FF, rx_word=9'h001 -> after 9 cycles out_valid=1, dec_value=1, err=0.
- en_flag=9'h1FF, rx_word=9'b101010101 -> dec_value=88 (1+3+8+21+55), err=0.
- en_flag=9'b111111011 (TSV2 faulty), rx_word=9'b000001000 -> dec_value=3, because TSV3 is the third enabled TSV.
- en_flag=9'h000, rx_word=9'h1FF -> dec_value=0. Then a second word is sent with en_flag=9'h1FF and rx_word=9'h100 -> dec_value=55.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, dec_value and err are stable, in_ready=0, and a new in_valid is not accepted. Raising out_ready gives IDLE on the next cycle.
- Reset, and check:
  - rst pulsed at RUN idx=4 -> next cycle out_valid=0, in_ready=1, dec_value=0. A fresh word with en=9'h1FF and rx=9'h010 decodes to 8.
  - With FNS_DECODER_CHECK_EN: en=9'h1FF, rx=9'h003 -> dec_value=3, err=1. With en=9'b111111101, rx=9'h005 -> err=1, because TSV1 is disabled and TSVs 0 and 2 are adjacent enabled ones.

Source files
------------

// File: rtl/fns_serial_decoder_if.sv
// Handshake bundle between the TSV receive array, the FNS decoder and the
// downstream binary datapath.
interface fns_serial_decoder_if #(
  parameter int N_TSV = 9,
  parameter int SUM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N_TSV-1:0] rx_word;
  logic [N_TSV-1:0] en_flag;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] dec_value;
  logic             err;

  // master: upstream TSV array plus downstream consumer
  modport master (
    output in_valid, rx_word, en_flag, out_ready,
    input  in_ready, out_valid, dec_value, err
  );

  modport slave (
    input  in_valid, rx_word, en_flag, out_ready,
    output in_ready, out_valid, dec_value, err
  );
endinterface

// File: rtl/fns_serial_decoder.sv
// Serial Fibonacci-numeral-system TSV decoder: walks one TSV per cycle, giving
// weights 1,2,3,5,... to enabled TSVs only. Optional FNS_DECODER_CHECK_EN adds adjacent-ones checking.
module fns_serial_decoder #(
  parameter int N_TSV = 9,
  parameter int SUM_W = 8,
  parameter int IDX_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  fns_serial_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TSV - 1);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] dec_value_q, dec_value_d;
  logic [N_TSV-1:0] rx_sh_q, rx_sh_d;
  logic [N_TSV-1:0] en_sh_q, en_sh_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] prev_q, prev_d;
  logic [SUM_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             en_bit, rx_bit;
  logic [SUM_W-1:0] acc_sum;

  assign en_bit  = en_sh_q[idx_q];
  assign rx_bit  = rx_sh_q[idx_q];
  assign acc_sum = acc_q + ((en_bit && rx_bit) ? cur_q : '0);

`ifdef FNS_DECODER_CHECK_EN
  // last_one tracks the rx bit of the most recent enabled TSV, so disabled
  // TSVs in between are transparent to the adjacency check.
  logic err_q, err_d;
  logic last_one_q, last_one_d;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dec_value_d = dec_value_q;
    rx_sh_d     = rx_sh_q;
    en_sh_d     = en_sh_q;
    acc_d       = acc_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    idx_d       = idx_q;
`ifdef FNS_DECODER_CHECK_EN
    err_d       = err_q;
    last_one_d  = last_one_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          rx_sh_d    = bus.rx_word;
          en_sh_d    = bus.en_flag;
          acc_d      = '0;
          idx_d      = '0;
          prev_d     = SUM_W'(1);
          cur_d      = SUM_W'(1);
          in_ready_d = 1'b0;
          state_d    = RUN;
`ifdef FNS_DECODER_CHECK_EN
          err_d      = 1'b0;
          last_one_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (en_bit) begin
          acc_d  = acc_sum;
          prev_d = cur_q;
          cur_d  = prev_q + cur_q;
`ifdef FNS_DECODER_CHECK_EN
          if (rx_bit && last_one_q) err_d = 1'b1;
          last_one_d = rx_bit;
`endif
        end
        if (idx_q == LAST_IDX) begin
          dec_value_d = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dec_value_q <= '0;
      rx_sh_q     <= '0;
      en_sh_q     <= '0;
      acc_q       <= '0;
      prev_q      <= SUM_W'(1);
      cur_q       <= SUM_W'(1);
      idx_q       <= '0;
`ifdef FNS_DECODER_CHECK_EN
      err_q       <= 1'b0;
      last_one_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dec_value_q <= dec_value_d;
      rx_sh_q     <= rx_sh_d;
      en_sh_q     <= en_sh_d;
      acc_q       <= acc_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      idx_q       <= idx_d;
`ifdef FNS_DECODER_CHECK_EN
      err_q       <= err_d;
      last_one_q  <= last_one_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dec_value = dec_value_q;
`ifdef FNS_DECODER_CHECK_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule
